// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue: entry payload, zero register, count width.
package wb_pkg;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned RD_W    = 5;

    localparam logic [RD_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [RD_W-1:0]    rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Combinational forwarding search: youngest valid FIFO entry wins, output register is the oldest candidate.
module wb_fwd_lookup
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                        ents [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]         head,
    input  logic [count_width(DEPTH)-1:0]    count,
    input  logic                             out_wen,
    input  wb_entry_t                        out_ent,
    input  logic [RD_W-1:0]                  q_rs,
    output logic                             hit_c,
    output logic [WB_XLEN-1:0]               data_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so later matches overwrite earlier ones.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        if (q_rs != REG_ZERO) begin
            if (out_wen && (out_ent.rd == q_rs)) begin
                hit_c  = 1'b1;
                data_c = out_ent.data;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && (ents[idx].rd == q_rs)) begin
                    hit_c  = 1'b1;
                    data_c = ents[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: two-result enqueue from ALU/LSU, one registered register-file write per cycle,
// plus forwarding of pending results. XLEN is expected to match wb_pkg::WB_XLEN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    output logic                          wb_wen,
    output logic [4:0]                    wb_rd,
    output logic [XLEN-1:0]               wb_wdata,
    input  logic [4:0]                    q_rs1,
    input  logic [4:0]                    q_rs2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [XLEN-1:0]               fwd_data1,
    output logic [XLEN-1:0]               fwd_data2,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    wb_entry_t          mem [DEPTH];
    wb_entry_t          out_ent;
    wb_entry_t          alu_ent;
    wb_entry_t          lsu_ent;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   lsu_slot;
    logic               alu_store;
    logic               lsu_store;
    logic               deq;
    logic [WB_XLEN-1:0] fwd_raw1;
    logic [WB_XLEN-1:0] fwd_raw2;

    // Space is judged on current occupancy only; the same-cycle dequeue is not credited.
    assign alu_ready = count < CNT_W'(DEPTH);
    assign lsu_ready = (count + CNT_W'(alu_valid)) < CNT_W'(DEPTH);

    // Writes to x0 complete the handshake but are dropped.
    assign alu_store = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    assign lsu_store = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);
    assign deq       = count != '0;
    assign lsu_slot  = tail + PTR_W'(alu_store);

    assign alu_ent = '{rd: alu_rd, data: WB_XLEN'(alu_data)};
    assign lsu_ent = '{rd: lsu_rd, data: WB_XLEN'(lsu_data)};

    assign wb_rd    = out_ent.rd;
    assign wb_wdata = XLEN'(out_ent.data);

    // Storage needs no reset: only entries inside [head, head+count) are ever observed.
    always_ff @(posedge clk) begin
        if (alu_store) begin
            mem[tail] <= alu_ent;
        end
        if (lsu_store) begin
            mem[lsu_slot] <= lsu_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wb_wen  <= 1'b0;
            out_ent <= '0;
        end else begin
            tail  <= tail + PTR_W'(alu_store) + PTR_W'(lsu_store);
            count <= count + CNT_W'(alu_store) + CNT_W'(lsu_store) - CNT_W'(deq);
            if (deq) begin
                wb_wen  <= 1'b1;
                out_ent <= mem[head];
                head    <= head + PTR_W'(1);
            end else begin
                wb_wen <= 1'b0;
            end
        end
    end

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .ents    (mem),
        .head    (head),
        .count   (count),
        .out_wen (wb_wen),
        .out_ent (out_ent),
        .q_rs    (q_rs1),
        .hit_c   (fwd_hit1),
        .data_c  (fwd_raw1)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .ents    (mem),
        .head    (head),
        .count   (count),
        .out_wen (wb_wen),
        .out_ent (out_ent),
        .q_rs    (q_rs2),
        .hit_c   (fwd_hit2),
        .data_c  (fwd_raw2)
    );

    assign fwd_data1 = XLEN'(fwd_raw1);
    assign fwd_data2 = XLEN'(fwd_raw2);

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table, reset corner sequences, then random traffic against a queue model.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            alu_valid, lsu_valid;
    logic [4:0]      alu_rd, lsu_rd, q_rs1, q_rs2, wb_rd;
    logic [XLEN-1:0] alu_data, lsu_data, wb_wdata, fwd_data1, fwd_data2;
    logic            alu_ready, lsu_ready, wb_wen, fwd_hit1, fwd_hit2;
    logic [2:0]      count;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Pre-edge samples of the combinational outputs.
    logic        p_ar, p_lr, p_h1, p_h2;
    logic [31:0] p_d1, p_d2;

    // Drive at negedge, sample comb outputs, cross one posedge, return at the next negedge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        q_rs1 = r1; q_rs2 = r2;
        #1;
        p_ar = alu_ready; p_lr = lsu_ready;
        p_h1 = fwd_hit1;  p_d1 = fwd_data1;
        p_h2 = fwd_hit2;  p_d2 = fwd_data2;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic [4:0]  rs;
        logic        ar;  logic lr; logic hit; logic [31:0] fd;
        int          cnt; logic wen; logic [4:0] wrd; logic [31:0] wd;
    } vec_t;

    vec_t vecs [17];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;

    // Youngest queued result first, then the result currently on the write port.
    function automatic void m_look(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d = 32'h0;
        if (rs == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
                hit = 1'b1;
                d = mq[i].data;
                return;
            end
        end
        if (m_wen && (m_rd == rs)) begin
            hit = 1'b1;
            d = m_wd;
        end
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0,        1, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 0, 1'b0, 5'd5, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0,       2, 1'b0, 5'd5, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h22,       1, 1'b1, 5'd3, 32'h11};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h22,       0, 1'b1, 5'd3, 32'h22};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 32'h22,       0, 1'b0, 5'd3, 32'h22};
        vecs[7]  = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,        0, 1'b0, 5'd3, 32'h22};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,        0, 1'b0, 5'd3, 32'h22};
        vecs[9]  = '{1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hA2, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0,       2, 1'b0, 5'd3, 32'h22};
        vecs[10] = '{1'b1, 5'd4, 32'hA4,       1'b1, 5'd6, 32'hA6, 5'd1, 1'b1, 1'b1, 1'b1, 32'hA1,      3, 1'b1, 5'd1, 32'hA1};
        vecs[11] = '{1'b1, 5'd7, 32'hA7,       1'b1, 5'd8, 32'hA8, 5'd6, 1'b1, 1'b0, 1'b1, 32'hA6,      3, 1'b1, 5'd2, 32'hA2};
        vecs[12] = '{1'b1, 5'd9, 32'hA9,       1'b1, 5'd10, 32'hAA, 5'd7, 1'b1, 1'b0, 1'b1, 32'hA7,     3, 1'b1, 5'd4, 32'hA4};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 32'hA9,       2, 1'b1, 5'd6, 32'hA6};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0,        1, 1'b1, 5'd7, 32'hA7};
        vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 32'hA9,       0, 1'b1, 5'd9, 32'hA9};
        vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 32'hA9,       0, 1'b0, 5'd9, 32'hA9};

        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
        q_rs1 = 5'd0; q_rs2 = 5'd0;

        // Asynchronous reset observed before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_wen",   32'(wb_wen),    32'h0);
        chk("rst_count", 32'(count),     32'h0);
        chk("rst_rd",    32'(wb_rd),     32'h0);
        chk("rst_wdata", wb_wdata,       32'h0);
        chk("rst_aready", 32'(alu_ready), 32'h1);
        chk("rst_lready", 32'(lsu_ready), 32'h1);
        chk("rst_hit1",  32'(fwd_hit1),  32'h0);
        chk("rst_data1", fwd_data1,      32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
                 vecs[i].rs, vecs[i].rs);
            chk($sformatf("v%0d_aready", i), 32'(p_ar), 32'(vecs[i].ar));
            chk($sformatf("v%0d_lready", i), 32'(p_lr), 32'(vecs[i].lr));
            chk($sformatf("v%0d_hit1", i),   32'(p_h1), 32'(vecs[i].hit));
            chk($sformatf("v%0d_data1", i),  p_d1,      vecs[i].fd);
            chk($sformatf("v%0d_hit2", i),   32'(p_h2), 32'(vecs[i].hit));
            chk($sformatf("v%0d_data2", i),  p_d2,      vecs[i].fd);
            chk($sformatf("v%0d_count", i),  32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_wen", i),    32'(wb_wen), 32'(vecs[i].wen));
            chk($sformatf("v%0d_wrd", i),    32'(wb_rd),  32'(vecs[i].wrd));
            chk($sformatf("v%0d_wdata", i),  wb_wdata,    vecs[i].wd);
        end

        // Reset pulse with three entries queued and one on the write port.
        step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hB2, 5'd0, 5'd0);
        step(1'b1, 5'd13, 32'hB3, 1'b1, 5'd14, 32'hB4, 5'd0, 5'd0);
        chk("mid_pre_count", 32'(count),  32'h3);
        chk("mid_pre_wen",   32'(wb_wen), 32'h1);
        chk("mid_pre_rd",    32'(wb_rd),  32'd11);
        alu_valid = 1'b0; lsu_valid = 1'b0; q_rs1 = 5'd13; q_rs2 = 5'd11;
        #2 reset = 1'b1;
        #1;
        chk("mid_count",  32'(count),     32'h0);
        chk("mid_wen",    32'(wb_wen),    32'h0);
        chk("mid_rd",     32'(wb_rd),     32'h0);
        chk("mid_wdata",  wb_wdata,       32'h0);
        chk("mid_aready", 32'(alu_ready), 32'h1);
        chk("mid_lready", 32'(lsu_ready), 32'h1);
        chk("mid_hit1",   32'(fwd_hit1),  32'h0);
        chk("mid_hit2",   32'(fwd_hit2),  32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14);
            chk($sformatf("post_rst%0d_wen", i),   32'(wb_wen), 32'h0);
            chk($sformatf("post_rst%0d_count", i), 32'(count),  32'h0);
            chk($sformatf("post_rst%0d_hit1", i),  32'(p_h1),   32'h0);
        end

        // Random traffic against the queue model; state is empty after reset.
        mq.delete();
        m_wen = 1'b0; m_rd = 5'd0; m_wd = 32'h0;
        for (int n = 0; n < 600; n++) begin
            logic        av, lv, e_ar, e_lr, eh1, eh2;
            logic [4:0]  ard, lrd, r1, r2;
            logic [31:0] ad, ld, ed1, ed2;
            ent_t        e;
            e_ar = mq.size() < DEPTH;
            av   = e_ar && ($urandom_range(3) != 0);
            lv   = $urandom_range(3) != 0;
            e_lr = (mq.size() + (av ? 1 : 0)) < DEPTH;
            ard  = 5'($urandom_range(7));
            lrd  = 5'($urandom_range(7));
            ad   = $urandom;
            ld   = $urandom;
            r1   = 5'($urandom_range(7));
            r2   = 5'($urandom_range(7));
            m_look(r1, eh1, ed1);
            m_look(r2, eh2, ed2);
            step(av, ard, ad, lv, lrd, ld, r1, r2);
            chk($sformatf("r%0d_aready", n), 32'(p_ar), 32'(e_ar));
            chk($sformatf("r%0d_lready", n), 32'(p_lr), 32'(e_lr));
            chk($sformatf("r%0d_hit1", n),   32'(p_h1), 32'(eh1));
            chk($sformatf("r%0d_data1", n),  p_d1,      ed1);
            chk($sformatf("r%0d_hit2", n),   32'(p_h2), 32'(eh2));
            chk($sformatf("r%0d_data2", n),  p_d2,      ed2);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wen = 1'b1; m_rd = e.rd; m_wd = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (av && e_ar && (ard != 5'd0)) mq.push_back('{ard, ad});
            if (lv && e_lr && (lrd != 5'd0)) mq.push_back('{lrd, ld});
            chk($sformatf("r%0d_count", n), 32'(count),  32'(mq.size()));
            chk($sformatf("r%0d_wen", n),   32'(wb_wen), 32'(m_wen));
            chk($sformatf("r%0d_wrd", n),   32'(wb_rd),  32'(m_rd));
            chk($sformatf("r%0d_wdata", n), wb_wdata,    m_wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
